// File: rtl/dff_rr_write_arbiter_if.sv
// Write-side bundle for the shared dff storage register: requests/data in, grant/storage state out.
// Latency: pure wiring, no storage of its own.
// Backpressure: requesters hold req/d_in until their gnt bit pulses; arbiter drives the rest.
//
// Ports (signals):
//   req   [NREQ]        level write request per requester
//   d_in  [NREQ*WIDTH]  per-requester write data, lane i at [i*WIDTH +: WIDTH]
//   gnt   [NREQ]        one-hot write acknowledge pulse
//   q/qbar[WIDTH]       stored value and its complement
//   owner [OW]          index of the last writer
//   valid, busy         written-since-clear flag, hold-window flag
interface dff_rr_write_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] d_in;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      qbar;
  logic [OW-1:0]         owner;
  logic                  valid;
  logic                  busy;

  // requester side
  modport master (
    output req, d_in,
    input  gnt, q, qbar, owner, valid, busy
  );

  // arbiter side
  modport slave (
    input  req, d_in,
    output gnt, q, qbar, owner, valid, busy
  );
endinterface

// File: rtl/dff_rr_write_arbiter.sv
// Round-robin write controller for one shared WIDTH-bit q/qbar storage register with a post-write hold window.
// Latency: req seen in IDLE -> q, owner and one-cycle gnt pulse registered 1 cycle later; next write at E+HOLD_CYC+1.
// Backpressure: losing or held-off requesters keep req/d_in stable until their gnt bit; req is ignored while busy.
//
// Ports:
//   clk    rising-edge clock for all state
//   clear  synchronous active-high reset, dominates everything in its cycle
//   bus    dff_rr_write_arbiter_if.slave: req/d_in in; gnt, q, qbar, owner, valid, busy out (all registered)
module dff_rr_write_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic                        clk,
  input  logic                        clear,
  dff_rr_write_arbiter_if.slave       bus
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HL = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;
  localparam logic [3:0]    HOLD_LOAD = HL[3:0];
  localparam logic [OW-1:0] LAST_RST  = OW'(NREQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [OW-1:0]     last_q, last_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  qbar_q, qbar_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic              valid_q, valid_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              busy_q, busy_d;

  // Round-robin search: scan from last+1 upward with wrap, first requester found wins.
  logic              found;
  logic [OW-1:0]     win;
  int                idx;
  logic [WIDTH-1:0]  win_dat;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx[OW-1:0];
      end
    end
  end

  assign win_dat = bus.d_in[int'(win)*WIDTH +: WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    q_d     = q_q;
    qbar_d  = qbar_q;
    owner_d = owner_q;
    valid_d = valid_q;
    gnt_d   = '0;
    busy_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          q_d        = win_dat;
          qbar_d     = ~win_dat;
          owner_d    = win;
          last_d     = win;
          valid_d    = 1'b1;
          gnt_d[win] = 1'b1;
          // With no hold window the arbiter stays in IDLE and can write every cycle.
          if (HOLD_CYC > 0) begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
            busy_d  = 1'b1;
          end
        end
      end
      HOLD: begin
        // busy is registered, so it stays high through the edge that reloads IDLE's first chance.
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= LAST_RST;
      q_q     <= '0;
      qbar_q  <= '1;
      owner_q <= '0;
      valid_q <= 1'b0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      q_q     <= q_d;
      qbar_q  <= qbar_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.q     = q_q;
  assign bus.qbar  = qbar_q;
  assign bus.owner = owner_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_dff_rr_write_arbiter.sv
// Bench for dff_rr_write_arbiter: one instance with a 2-cycle hold window, one with none.
// Latency: expectations are queued per arbitration edge and checked at the following falling edge.
// Backpressure: bench requesters hold req/d_in until the reference model says they were granted.
module tb_dff_rr_write_arbiter;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  dff_rr_write_arbiter_if #(.NREQ(4), .WIDTH(8)) ifa ();
  dff_rr_write_arbiter_if #(.NREQ(4), .WIDTH(8)) ifb ();

  logic        clear_v [2];
  logic [3:0]  req_v   [2];
  logic [31:0] din_v   [2];

  assign ifa.req  = req_v[0];
  assign ifa.d_in = din_v[0];
  assign ifb.req  = req_v[1];
  assign ifb.d_in = din_v[1];

  dff_rr_write_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYC(2)) dut_a (
    .clk   (clk),
    .clear (clear_v[0]),
    .bus   (ifa.slave)
  );

  dff_rr_write_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYC(0)) dut_b (
    .clk   (clk),
    .clear (clear_v[1]),
    .bus   (ifb.slave)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [7:0] q;
    logic [7:0] qbar;
    logic [1:0] owner;
    logic       valid;
    logic       busy;
  } exp_t;

  // Reference model: a write is allowed when no hold edges are left; each write books HOLD edges.
  typedef struct {
    int         last;
    int         hold_left;
    logic [7:0] q;
    int         owner;
    logic       valid;
    logic [3:0] g;
  } ms_t;

  ms_t  ms [2];
  int   hold_of [2];
  exp_t qa [$];
  exp_t qb [$];

  int tests;
  int fails;

  task automatic model_eval(input int k);
    exp_t e;
    int   w;
    if (clear_v[k]) begin
      ms[k].last      = 3;
      ms[k].hold_left = 0;
      ms[k].q         = 8'h00;
      ms[k].owner     = 0;
      ms[k].valid     = 1'b0;
      ms[k].g         = 4'b0000;
    end else if (ms[k].hold_left > 0) begin
      ms[k].hold_left = ms[k].hold_left - 1;
      ms[k].g         = 4'b0000;
    end else if (req_v[k] != 4'b0000) begin
      w = -1;
      for (int off = 1; off <= 4; off++) begin
        if (w < 0 && req_v[k][(ms[k].last + off) % 4]) w = (ms[k].last + off) % 4;
      end
      ms[k].q         = din_v[k][w*8 +: 8];
      ms[k].owner     = w;
      ms[k].last      = w;
      ms[k].valid     = 1'b1;
      ms[k].hold_left = hold_of[k];
      ms[k].g         = 4'(1 << w);
    end else begin
      ms[k].g = 4'b0000;
    end
    e.gnt   = ms[k].g;
    e.q     = ms[k].q;
    e.qbar  = ~ms[k].q;
    e.owner = 2'(ms[k].owner);
    e.valid = ms[k].valid;
    e.busy  = (ms[k].hold_left > 0);
    if (k == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  task automatic step();
    model_eval(0);
    model_eval(1);
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d t=%0t actual=%h expected=%h", name, k, $time, act, exp);
    end
  endtask

  task automatic chk_all(input int k, input exp_t e, input logic [3:0] g, input logic [7:0] q,
                         input logic [7:0] qb_, input logic [1:0] own, input logic vld, input logic bsy);
    chk("gnt",   k, {4'b0, g},    {4'b0, e.gnt});
    chk("q",     k, q,            e.q);
    chk("qbar",  k, qb_,          e.qbar);
    chk("owner", k, {6'b0, own},  {6'b0, e.owner});
    chk("valid", k, {7'b0, vld},  {7'b0, e.valid});
    chk("busy",  k, {7'b0, bsy},  {7'b0, e.busy});
  endtask

  // Monitor: independent of stimulus, pops one expectation per edge and compares all outputs.
  always @(negedge clk) begin
    exp_t e;
    if (qa.size() != 0) begin
      e = qa.pop_front();
      chk_all(0, e, ifa.gnt, ifa.q, ifa.qbar, ifa.owner, ifa.valid, ifa.busy);
    end
    if (qb.size() != 0) begin
      e = qb.pop_front();
      chk_all(1, e, ifb.gnt, ifb.q, ifb.qbar, ifb.owner, ifb.valid, ifb.busy);
    end
  end

  // Random requester behaviour driven from the model's grant for the edge just passed.
  task automatic rand_drive(input int k);
    for (int i = 0; i < 4; i++) begin
      if (req_v[k][i]) begin
        if (ms[k].g[i]) begin
          if ($urandom_range(0, 3) == 0) din_v[k][i*8 +: 8] = 8'($urandom);
          else                           req_v[k][i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req_v[k][i] = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        req_v[k][i]        = 1'b1;
        din_v[k][i*8 +: 8] = 8'($urandom);
      end else begin
        din_v[k][i*8 +: 8] = 8'($urandom);
      end
    end
    clear_v[k] = ($urandom_range(0, 59) == 0);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    hold_of[0] = 2;
    hold_of[1] = 0;
    for (int k = 0; k < 2; k++) begin
      ms[k].last      = 3;
      ms[k].hold_left = 0;
      ms[k].q         = 8'h00;
      ms[k].owner     = 0;
      ms[k].valid     = 1'b0;
      ms[k].g         = 4'b0000;
      clear_v[k]      = 1'b1;
      req_v[k]        = 4'b0000;
      din_v[k]        = $urandom;
    end

    // Reset dominance: all requests raised while clear is high.
    req_v[0] = 4'b1111;
    req_v[1] = 4'b1111;
    steps(2);
    req_v[0] = 4'b0000;
    req_v[1] = 4'b0000;
    clear_v[0] = 1'b0;
    step();

    // Single write from lane 0, then the hold window runs out.
    req_v[0] = 4'b0001;
    din_v[0][7:0] = 8'hA5;
    step();
    req_v[0] = 4'b0000;
    steps(4);

    // Round-robin with all requests held from a fresh pointer.
    clear_v[0] = 1'b1;
    step();
    clear_v[0] = 1'b0;
    req_v[0] = 4'b1111;
    din_v[0] = 32'h13121110;
    steps(13);
    req_v[0] = 4'b0000;
    steps(3);

    // Request arriving during the hold window must wait.
    req_v[0] = 4'b0100;
    din_v[0][23:16] = 8'h3C;
    step();
    req_v[0] = 4'b0010;
    din_v[0][15:8] = 8'hC3;
    steps(3);
    req_v[0] = 4'b0000;
    steps(3);

    // Clear in the second busy cycle resets the pointer.
    req_v[0] = 4'b0001;
    din_v[0][7:0] = 8'h77;
    step();
    req_v[0] = 4'b0000;
    step();
    clear_v[0] = 1'b1;
    step();
    clear_v[0] = 1'b0;
    req_v[0] = 4'b1010;
    din_v[0] = 32'h5A00E100;
    step();
    req_v[0] = 4'b0000;
    steps(3);

    // No hold window: two requesters alternate every cycle.
    clear_v[1] = 1'b0;
    req_v[1] = 4'b0101;
    din_v[1] = 32'h00040001;
    steps(6);
    req_v[1] = 4'b0000;
    step();

    // Randomized traffic on both instances.
    for (int c = 0; c < 500; c++) begin
      rand_drive(0);
      rand_drive(1);
      step();
    end

    clear_v[0] = 1'b0;
    clear_v[1] = 1'b0;
    req_v[0]   = 4'b0000;
    req_v[1]   = 4'b0000;
    steps(3);
    @(negedge clk);
    #1;
    tests++;
    if (qa.size() + qb.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d expected=0", qa.size() + qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
